param_mod_counter: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/param_mod_counter_bin_to_bcd.sv | 25 ++
 rtl/param_mod_counter.sv | 108 ++++++++++
 tb/tb_param_mod_counter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and elaboration helpers for the stopwatch timebase chain.
package stopwatch_pkg;

   localparam int SEC_MODULUS = 60;
   localparam int MIN_MODULUS = 120;
   localparam int MODE_WRAP   = 0;
   localparam int MODE_SAT    = 1;

   // Smallest r with 2**r >= value; sizes a counter that must hold 0..value-1.
   function automatic int clog2(input longint value);
      int     r = 0;
      longint v = 1;
      while (v < value) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

   function automatic longint pow10(input int digits);
      longint p = 1;
      for (int i = 0; i < digits; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

endpackage

// File: rtl/param_mod_counter_bin_to_bcd.sv
// Combinational double-dabble binary to packed BCD, least significant digit in bcd[3:0].
// Zero latency; no handshake, output follows input in the same cycle.
module bin_to_bcd #(
   parameter int WIDTH      = 8,
   parameter int BCD_DIGITS = 3
) (
   input  logic [WIDTH-1:0]        bin,
   output logic [4*BCD_DIGITS-1:0] bcd
);

   always_comb begin
      logic [4*BCD_DIGITS-1:0] acc;
      acc = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         for (int d = 0; d < BCD_DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
               acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
         end
         acc = {acc[4*BCD_DIGITS-2:0], bin[i]};
      end
      bcd = acc;
   end

endmodule

// File: rtl/param_mod_counter.sv
// Cascadable modulo-N up/down counter with wrap/saturate, clear, load and sticky limit flag.
// Count registered, carry_out combinational for same-edge cascading; optional registered bcd under PARAM_MOD_COUNTER_BCD_EN.
module param_mod_counter
   import stopwatch_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MODULUS    = 120,
   parameter int SAT_MODE   = MODE_WRAP,
   parameter int BCD_DIGITS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             carry_out,
   output logic             limit_hit
`ifdef PARAM_MOD_COUNTER_BCD_EN
   ,
   output logic [4*BCD_DIGITS-1:0] bcd
`endif
);

   if (MODULUS < 2 || clog2(longint'(MODULUS)) > WIDTH) begin : g_bad_modulus
      $error("param_mod_counter: MODULUS %0d must lie in 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
   end
   if (pow10(BCD_DIGITS) < longint'(MODULUS)) begin : g_bad_bcd_digits
      $error("param_mod_counter: BCD_DIGITS %0d too few for MODULUS %0d", BCD_DIGITS, MODULUS);
   end

   localparam bit               SAT     = (SAT_MODE != MODE_WRAP);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             limit_hit_q, limit_hit_d;
   logic             terminal, term, load_in_range;

   assign terminal      = up_dn ? (count_q == MAX_CNT) : (count_q == '0);
   assign term          = en & ~clear & ~load & terminal;
   assign load_in_range = ({1'b0, load_value} < MOD_EXT);

   always_comb begin
      count_d     = count_q;
      limit_hit_d = limit_hit_q;
      if (clear) begin
         count_d     = '0;
         limit_hit_d = 1'b0;
      end else if (load) begin
         count_d = load_in_range ? load_value : MAX_CNT;
      end else if (term) begin
         // Saturating stages hold at the end of range and only raise the flag.
         if (SAT) begin
            limit_hit_d = 1'b1;
         end else begin
            count_d = up_dn ? '0 : MAX_CNT;
         end
      end else if (en) begin
         count_d = up_dn ? WIDTH'({1'b0, count_q} + ONE_EXT)
                         : WIDTH'({1'b0, count_q} - ONE_EXT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= '0;
         limit_hit_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         limit_hit_q <= limit_hit_d;
      end
   end

   assign count     = count_q;
   assign limit_hit = limit_hit_q;
   assign carry_out = term & ~SAT;

`ifdef PARAM_MOD_COUNTER_BCD_EN
   logic [4*BCD_DIGITS-1:0] bcd_conv, bcd_d, bcd_q;

   bin_to_bcd #(
      .WIDTH      (WIDTH),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_bin_to_bcd (
      .bin (count_q),
      .bcd (bcd_conv)
   );

   always_comb begin
      bcd_d = clear ? '0 : bcd_conv;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_q <= '0;
      end else begin
         bcd_q <= bcd_d;
      end
   end

   assign bcd = bcd_q;
`endif

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed bench for param_mod_counter: wrap, saturate, load/priority, power-of-two modulus, cascade, optional BCD.
module tb_param_mod_counter;
   import stopwatch_pkg::*;

   localparam int SEC_W = clog2(SEC_MODULUS);
   localparam int MIN_W = clog2(MIN_MODULUS);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // main wrap counter, modulus 120
   logic       m_en, m_up, m_clear, m_load;
   logic [7:0] m_lv, m_count;
   logic       m_carry, m_lim;
   // saturating counter, modulus 120
   logic       s_en, s_up, s_clear, s_load;
   logic [7:0] s_lv, s_count;
   logic       s_carry, s_lim;
   // power-of-two modulus 8 in 3 bits
   logic       p_en, p_up, p_clear, p_load;
   logic [2:0] p_lv, p_count;
   logic       p_carry, p_lim;
   // seconds -> minutes cascade
   logic             c_en;
   logic [SEC_W-1:0] sec_count;
   logic [MIN_W-1:0] min_count;
   logic             sec_carry, min_carry, sec_lim, min_lim;
`ifdef PARAM_MOD_COUNTER_BCD_EN
   logic [11:0] m_bcd, s_bcd, min_bcd;
   logic [3:0]  p_bcd;
   logic [7:0]  sec_bcd;
`endif

   param_mod_counter #(.WIDTH(8), .MODULUS(120), .SAT_MODE(MODE_WRAP), .BCD_DIGITS(3)) u_main (
      .clk(clk), .rst(rst), .en(m_en), .up_dn(m_up), .clear(m_clear), .load(m_load),
      .load_value(m_lv), .count(m_count), .carry_out(m_carry), .limit_hit(m_lim)
`ifdef PARAM_MOD_COUNTER_BCD_EN
      , .bcd(m_bcd)
`endif
   );

   param_mod_counter #(.WIDTH(8), .MODULUS(120), .SAT_MODE(MODE_SAT), .BCD_DIGITS(3)) u_sat (
      .clk(clk), .rst(rst), .en(s_en), .up_dn(s_up), .clear(s_clear), .load(s_load),
      .load_value(s_lv), .count(s_count), .carry_out(s_carry), .limit_hit(s_lim)
`ifdef PARAM_MOD_COUNTER_BCD_EN
      , .bcd(s_bcd)
`endif
   );

   param_mod_counter #(.WIDTH(3), .MODULUS(8), .SAT_MODE(MODE_WRAP), .BCD_DIGITS(1)) u_pow2 (
      .clk(clk), .rst(rst), .en(p_en), .up_dn(p_up), .clear(p_clear), .load(p_load),
      .load_value(p_lv), .count(p_count), .carry_out(p_carry), .limit_hit(p_lim)
`ifdef PARAM_MOD_COUNTER_BCD_EN
      , .bcd(p_bcd)
`endif
   );

   param_mod_counter #(.WIDTH(SEC_W), .MODULUS(SEC_MODULUS), .SAT_MODE(MODE_WRAP), .BCD_DIGITS(2)) u_sec (
      .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .clear(1'b0), .load(1'b0),
      .load_value('0), .count(sec_count), .carry_out(sec_carry), .limit_hit(sec_lim)
`ifdef PARAM_MOD_COUNTER_BCD_EN
      , .bcd(sec_bcd)
`endif
   );

   param_mod_counter #(.WIDTH(MIN_W), .MODULUS(MIN_MODULUS), .SAT_MODE(MODE_WRAP), .BCD_DIGITS(3)) u_min (
      .clk(clk), .rst(rst), .en(sec_carry), .up_dn(1'b1), .clear(1'b0), .load(1'b0),
      .load_value('0), .count(min_count), .carry_out(min_carry), .limit_hit(min_lim)
`ifdef PARAM_MOD_COUNTER_BCD_EN
      , .bcd(min_bcd)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, observed running, expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      {m_en, m_up, m_clear, m_load} = '0;  m_lv = '0;
      {s_en, s_up, s_clear, s_load} = '0;  s_lv = '0;
      {p_en, p_up, p_clear, p_load} = '0;  p_lv = '0;
      c_en = 1'b0;
      rst  = 1'b1;
      step();
      step();
      check("rst_count", 32'(m_count), 0);
      check("rst_limit", 32'(m_lim), 0);
      check("rst_carry", 32'(m_carry), 0);
      check("rst_sat_count", 32'(s_count), 0);

      // up-count wrap over the full range
      rst = 1'b0; m_en = 1'b1; m_up = 1'b1;
      for (int i = 0; i < 120; i++) begin
         #1;
         check("up_count", 32'(m_count), 32'(i));
         check("up_carry", 32'(m_carry), 32'(i == 119));
         check("up_limit", 32'(m_lim), 0);
         step();
      end
      check("up_wrap", 32'(m_count), 0);
      check("up_wrap_limit", 32'(m_lim), 0);

      // down-count wrap from reset, then a direction change mid-count
      rst = 1'b1; m_en = 1'b0;
      step();
      rst = 1'b0; m_en = 1'b1; m_up = 1'b0;
      #1;
      check("dn_carry_at0", 32'(m_carry), 1);
      step();
      check("dn_wrap", 32'(m_count), 119);
      check("dn_carry_119", 32'(m_carry), 0);
      step();
      check("dn_118", 32'(m_count), 118);
      m_up = 1'b1;
      step();
      check("dir_up", 32'(m_count), 119);
      check("dir_up_carry", 32'(m_carry), 1);
      m_up = 1'b0;
      step();
      check("dir_dn", 32'(m_count), 118);

      // load clamping and priority
      m_en = 1'b0; m_load = 1'b1; m_lv = 8'd200;
      step();
      check("load_clamp200", 32'(m_count), 119);
      m_lv = 8'd120;
      step();
      check("load_clamp120", 32'(m_count), 119);
      m_lv = 8'd50; m_en = 1'b1;
      step();
      check("load_over_en", 32'(m_count), 50);
      m_clear = 1'b1;
      step();
      check("clear_over_load", 32'(m_count), 0);
      m_clear = 1'b0; m_en = 1'b0; m_lv = 8'd77;
      step();
      check("load_77", 32'(m_count), 77);
      m_lv = 8'd5; rst = 1'b1;
      step();
      check("rst_over_load", 32'(m_count), 0);
      rst = 1'b0; m_lv = 8'd119;
      step();
      m_en = 1'b1; m_up = 1'b1; m_lv = 8'd3;
      #1;
      check("carry_masked_load", 32'(m_carry), 0);
      step();
      check("load_at_term", 32'(m_count), 3);
      m_en = 1'b0; m_lv = 8'd119;
      step();
      m_load = 1'b0; m_en = 1'b1; m_clear = 1'b1;
      #1;
      check("carry_masked_clear", 32'(m_carry), 0);
      step();
      check("clear_over_en", 32'(m_count), 0);
      m_clear = 1'b0; m_en = 1'b0;

`ifdef PARAM_MOD_COUNTER_BCD_EN
      m_load = 1'b1; m_lv = 8'd107;
      step();
      check("bcd_load_count", 32'(m_count), 107);
      m_load = 1'b0;
      step();
      check("bcd_107", 32'(m_bcd), 32'h107);
      rst = 1'b1;
      step();
      check("bcd_rst", 32'(m_bcd), 0);
      rst = 1'b0; m_load = 1'b1; m_lv = 8'd42;
      step();
      m_load = 1'b0;
      step();
      check("bcd_42", 32'(m_bcd), 32'h042);
      m_clear = 1'b1;
      step();
      check("bcd_clear", 32'(m_bcd), 0);
      m_clear = 1'b0;
`endif

      // saturate mode
      s_load = 1'b1; s_lv = 8'd118;
      step();
      check("sat_load", 32'(s_count), 118);
      s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("sat_carry", 32'(s_carry), 0);
         step();
         check("sat_count", 32'(s_count), 119);
         check("sat_limit", 32'(s_lim), 32'(i >= 1));
      end
      s_en = 1'b0; s_load = 1'b1; s_lv = 8'd10;
      step();
      check("sat_load_keeps_limit", 32'(s_lim), 1);
      check("sat_load_10", 32'(s_count), 10);
      s_load = 1'b0; s_clear = 1'b1;
      step();
      check("sat_clear_count", 32'(s_count), 0);
      check("sat_clear_limit", 32'(s_lim), 0);
      s_clear = 1'b0; s_en = 1'b1; s_up = 1'b0;
      #1;
      check("sat_dn_carry", 32'(s_carry), 0);
      step();
      check("sat_dn_hold", 32'(s_count), 0);
      check("sat_dn_limit", 32'(s_lim), 1);
      s_en = 1'b0;

      // modulus equal to 2**WIDTH
      p_load = 1'b1; p_lv = 3'd7;
      step();
      p_load = 1'b0; p_en = 1'b1; p_up = 1'b1;
      #1;
      check("pow2_carry_up", 32'(p_carry), 1);
      step();
      check("pow2_wrap_up", 32'(p_count), 0);
      p_up = 1'b0;
      #1;
      check("pow2_carry_dn", 32'(p_carry), 1);
      step();
      check("pow2_wrap_dn", 32'(p_count), 7);
      step();
      check("pow2_dn_6", 32'(p_count), 6);
      p_en = 1'b0;

      // seconds -> minutes cascade
      rst = 1'b1;
      step();
      rst = 1'b0; c_en = 1'b1;
      repeat (3600) step();
      check("casc_sec_3600", 32'(sec_count), 0);
      check("casc_min_3600", 32'(min_count), 60);
      repeat (3599) step();
      check("casc_sec_7199", 32'(sec_count), 59);
      check("casc_min_7199", 32'(min_count), 119);
      check("casc_sec_carry", 32'(sec_carry), 1);
      check("casc_min_carry", 32'(min_carry), 1);
      step();
      check("casc_sec_wrap", 32'(sec_count), 0);
      check("casc_min_wrap", 32'(min_count), 0);
      c_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
